// File: rtl/branch_predictor.sv
// branch_predictor: direct-mapped BTB with 2-bit saturating counters, ID-stage
// mispredict detection, PC redirect and branch/mispredict statistics.
`timescale 1ns/1ps
module branch_predictor #(
    parameter int INDEX_BITS = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        id_pred_taken,
    input  logic [31:0] id_pred_target,
    input  logic        id_branch,
    input  logic [31:0] id_target,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);
    localparam int ENTRIES  = 1 << INDEX_BITS;
    localparam int TAG_BITS = 32 - INDEX_BITS - 2;
    logic [ENTRIES-1:0]    valid;
    logic [TAG_BITS-1:0]   tag    [ENTRIES];
    logic [31:0]           target [ENTRIES];
    logic [1:0]            ctr    [ENTRIES];
    logic [INDEX_BITS-1:0] if_idx, id_idx;
    logic                  if_hit, id_hit, mispredict;
    always_comb begin
        if_idx      = if_pc[INDEX_BITS+1:2];
        id_idx      = id_pc[INDEX_BITS+1:2];
        if_hit      = if_valid & valid[if_idx] & (tag[if_idx] == if_pc[31:INDEX_BITS+2]);
        id_hit      = valid[id_idx] & (tag[id_idx] == id_pc[31:INDEX_BITS+2]);
        pred_taken  = if_hit & ctr[if_idx][1];
        pred_target = pred_taken ? target[if_idx] : if_pc + 32'd4;
        mispredict  = id_valid & ((id_branch != id_pred_taken) |
                      (id_branch & id_pred_taken & (id_pred_target != id_target)));
        redirect    = mispredict;
        redirect_pc = id_branch ? id_target : id_pc + 32'd4;
    end
    // Prediction reads the registered tables, so a same-cycle update is seen next cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid       <= '0;
            branch_cnt  <= '0;
            mispred_cnt <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                tag[i]    <= '0;
                target[i] <= '0;
                ctr[i]    <= 2'b01;
            end
        end else if (id_valid) begin
            branch_cnt  <= branch_cnt + 32'd1;
            mispred_cnt <= mispred_cnt + {31'd0, mispredict};
            if (id_hit) begin
                ctr[id_idx] <= id_branch ? ((ctr[id_idx] == 2'b11) ? 2'b11 : ctr[id_idx] + 2'd1)
                                         : ((ctr[id_idx] == 2'b00) ? 2'b00 : ctr[id_idx] - 2'd1);
                if (id_branch) target[id_idx] <= id_target;
            end else if (id_branch) begin
                valid[id_idx]  <= 1'b1;
                tag[id_idx]    <= id_pc[31:INDEX_BITS+2];
                target[id_idx] <= id_target;
                ctr[id_idx]    <= 2'b10;
            end
        end
    end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed vector table, hand sequences and randomized
// traffic checked against an abstract BTB reference model.
`timescale 1ns/1ps
module tb_branch_predictor;
    typedef struct {
        logic        if_v;
        logic [31:0] if_pc;
        logic        id_v;
        logic [31:0] id_pc;
        logic        id_pt;
        logic [31:0] id_ptgt;
        logic        id_br;
        logic [31:0] id_tgt;
        logic        e_pt;
        logic [31:0] e_ptgt;
        logic        e_rd;
        logic [31:0] e_rpc;
        logic [31:0] e_bc;
        logic [31:0] e_mc;
    } vec_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        if_valid = 1'b0, id_valid = 1'b0, id_pred_taken = 1'b0, id_branch = 1'b0;
    logic [31:0] if_pc = '0, id_pc = '0, id_pred_target = '0, id_target = '0;
    logic        pred_taken, redirect;
    logic [31:0] pred_target, redirect_pc, branch_cnt, mispred_cnt;
    int          total = 0, bad = 0;

    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    logic [31:0] m_bc, m_mc;
    vec_t        vecs    [16];

    branch_predictor dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_pred_taken(id_pred_taken), .id_pred_target(id_pred_target),
        .id_branch(id_branch), .id_target(id_target),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", n, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [31:0] a, b, c, d, e, f, g, h, i, j, k, l, m, n);
        vec_t r;
        r.if_v = a[0]; r.if_pc = b; r.id_v = c[0]; r.id_pc = d; r.id_pt = e[0]; r.id_ptgt = f;
        r.id_br = g[0]; r.id_tgt = h; r.e_pt = i[0]; r.e_ptgt = j; r.e_rd = k[0]; r.e_rpc = l;
        r.e_bc = m; r.e_mc = n;
        return r;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_bc = '0; m_mc = '0;
    endfunction

    function automatic bit m_mis(input bit pt, input logic [31:0] ptgt, input bit br, input logic [31:0] tgt);
        return (br != pt) || (br && tgt != ptgt);
    endfunction

    function automatic bit m_taken(input bit vld, input logic [31:0] pc);
        int idx = int'((pc >> 2) % 16);
        return vld && m_valid[idx] && m_tag[idx] == (pc >> 6) && m_ctr[idx] >= 2;
    endfunction

    function automatic logic [31:0] m_target(input bit vld, input logic [31:0] pc);
        return m_taken(vld, pc) ? m_tgt[int'((pc >> 2) % 16)] : pc + 32'd4;
    endfunction

    function automatic void m_update();
        int idx = int'((id_pc >> 2) % 16);
        m_bc = m_bc + 1;
        if (m_mis(id_pred_taken, id_pred_target, id_branch, id_target)) m_mc = m_mc + 1;
        if (m_valid[idx] && m_tag[idx] == (id_pc >> 6)) begin
            m_ctr[idx] = id_branch ? (m_ctr[idx] < 3 ? m_ctr[idx] + 1 : 3)
                                   : (m_ctr[idx] > 0 ? m_ctr[idx] - 1 : 0);
            if (id_branch) m_tgt[idx] = id_target;
        end else if (id_branch) begin
            m_valid[idx] = 1; m_tag[idx] = id_pc >> 6; m_tgt[idx] = id_target; m_ctr[idx] = 2;
        end
    endfunction

    task automatic tick();
        if (id_valid && !rst) m_update();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rnd_pc();
        return 32'h1000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 3) << 2);
    endfunction

    task automatic chk_model(input string tag);
        chk({tag, "_pred_taken"}, {31'd0, pred_taken}, {31'd0, m_taken(if_valid, if_pc)});
        chk({tag, "_pred_target"}, pred_target, m_target(if_valid, if_pc));
        chk({tag, "_redirect"}, {31'd0, redirect},
            {31'd0, id_valid && m_mis(id_pred_taken, id_pred_target, id_branch, id_target)});
        chk({tag, "_redirect_pc"}, redirect_pc, id_branch ? id_target : id_pc + 32'd4);
        chk({tag, "_branch_cnt"}, branch_cnt, m_bc);
        chk({tag, "_mispred_cnt"}, mispred_cnt, m_mc);
    endtask

    initial begin
        vecs[0]  = v(1, 'h100, 1, 'h100, 0, 'h104, 1, 'h80,  0, 'h104, 1, 'h80,  0, 0);
        vecs[1]  = v(1, 'h100, 1, 'h100, 1, 'h80,  1, 'h80,  1, 'h80,  0, 'h80,  1, 1);
        vecs[2]  = v(1, 'h100, 1, 'h100, 1, 'h80,  1, 'h80,  1, 'h80,  0, 'h80,  2, 1);
        vecs[3]  = v(1, 'h100, 1, 'h100, 1, 'h80,  1, 'h80,  1, 'h80,  0, 'h80,  3, 1);
        vecs[4]  = v(1, 'h100, 1, 'h100, 1, 'h80,  1, 'h80,  1, 'h80,  0, 'h80,  4, 1);
        vecs[5]  = v(1, 'h100, 1, 'h100, 1, 'h80,  0, 'h80,  1, 'h80,  1, 'h104, 5, 1);
        vecs[6]  = v(1, 'h100, 1, 'h100, 1, 'h80,  0, 'h80,  1, 'h80,  1, 'h104, 6, 2);
        vecs[7]  = v(1, 'h100, 0, 'h100, 0, 'h104, 0, 'h80,  0, 'h104, 0, 'h104, 7, 3);
        vecs[8]  = v(1, 'h100, 1, 'h100, 1, 'h80,  1, 'h90,  0, 'h104, 1, 'h90,  7, 3);
        vecs[9]  = v(1, 'h100, 0, 'h100, 1, 'h90,  1, 'h90,  1, 'h90,  0, 'h90,  8, 4);
        vecs[10] = v(1, 'h100, 1, 'h140, 0, 'h144, 1, 'h200, 1, 'h90,  1, 'h200, 8, 4);
        vecs[11] = v(1, 'h140, 0, 'h140, 0, 'h144, 1, 'h200, 1, 'h200, 0, 'h200, 9, 5);
        vecs[12] = v(1, 'h100, 1, 'h180, 0, 'h184, 0, 'h300, 0, 'h104, 0, 'h184, 9, 5);
        vecs[13] = v(1, 'h140, 0, 'h180, 0, 'h184, 0, 'h300, 1, 'h200, 0, 'h184, 10, 5);
        vecs[14] = v(0, 'h140, 0, 'h180, 0, 'h184, 1, 'h300, 0, 'h144, 0, 'h300, 10, 5);
        vecs[15] = v(1, 'hFFFFFFFC, 0, 'hFFFFFFFC, 0, 0, 0, 0, 0, 0, 0, 0, 10, 5);
        m_reset();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 16; i++) begin
            if_valid = vecs[i].if_v; if_pc = vecs[i].if_pc; id_valid = vecs[i].id_v;
            id_pc = vecs[i].id_pc; id_pred_taken = vecs[i].id_pt; id_pred_target = vecs[i].id_ptgt;
            id_branch = vecs[i].id_br; id_target = vecs[i].id_tgt;
            #1;
            chk($sformatf("vec%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].e_pt});
            chk($sformatf("vec%0d_pred_target", i), pred_target, vecs[i].e_ptgt);
            chk($sformatf("vec%0d_redirect", i), {31'd0, redirect}, {31'd0, vecs[i].e_rd});
            chk($sformatf("vec%0d_redirect_pc", i), redirect_pc, vecs[i].e_rpc);
            chk($sformatf("vec%0d_branch_cnt", i), branch_cnt, vecs[i].e_bc);
            chk($sformatf("vec%0d_mispred_cnt", i), mispred_cnt, vecs[i].e_mc);
            tick();
        end

        // Asynchronous reset mid-run: 0x140 is predicted taken until rst rises.
        if_valid = 1'b1; if_pc = 32'h140; id_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("rst_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("rst_pred_target", pred_target, 32'h144);
        chk("rst_branch_cnt", branch_cnt, 32'd0);
        chk("rst_mispred_cnt", mispred_cnt, 32'd0);
        #1 rst = 1'b0;
        m_reset();
        tick();

        // Same-cycle read and write of one entry returns the old target.
        id_valid = 1'b1; id_pc = 32'h100; id_pred_taken = 1'b0; id_pred_target = 32'h104;
        id_branch = 1'b1; id_target = 32'h80;
        tick();
        if_pc = 32'h100; id_pred_taken = 1'b1; id_pred_target = 32'h80; id_target = 32'h90;
        #1;
        chk("simul_old_taken", {31'd0, pred_taken}, 32'd1);
        chk("simul_old_target", pred_target, 32'h80);
        chk("simul_redirect", {31'd0, redirect}, 32'd1);
        tick();
        id_valid = 1'b0;
        #1;
        chk("simul_new_target", pred_target, 32'h90);

        // Statistics counter wrap.
        force dut.branch_cnt = 32'hFFFFFFFF;
        #1 release dut.branch_cnt;
        #1;
        chk("wrap_forced", branch_cnt, 32'hFFFFFFFF);
        id_valid = 1'b1; id_pc = 32'h200; id_pred_taken = 1'b0; id_pred_target = 32'h204;
        id_branch = 1'b0; id_target = 32'h0;
        tick();
        id_valid = 1'b0;
        #1;
        chk("wrap_branch_cnt", branch_cnt, 32'd0);

        #1 rst = 1'b1;
        #1 rst = 1'b0;
        m_reset();
        tick();

        for (int n = 0; n < 400; n++) begin
            if_valid = $urandom_range(0, 7) != 0;
            if_pc = rnd_pc();
            id_valid = $urandom_range(0, 2) != 0;
            id_pc = rnd_pc();
            id_pred_taken = m_taken(1'b1, id_pc);
            id_pred_target = m_target(1'b1, id_pc);
            if ($urandom_range(0, 3) == 0) id_pred_taken = $urandom_range(0, 1) == 1;
            if ($urandom_range(0, 3) == 0) id_pred_target = 32'h2000 + ($urandom_range(0, 3) << 4);
            id_branch = $urandom_range(0, 1) == 1;
            id_target = 32'h2000 + ($urandom_range(0, 3) << 4);
            if ($urandom_range(0, 99) == 0) begin
                #1 rst = 1'b1;
                m_reset();
                #1;
                chk_model("rnd_rst");
                rst = 1'b0;
            end else begin
                #1;
                chk_model("rnd");
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
